ft600_fifo_arbiter: RTL and testbench

FT600_FIFO_ARBITER -- requirements
Module: ft600_fifo_arbiter

---
 rtl/ft600_pkg.sv | 19 +
 rtl/ft600_fifo_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_ft600_fifo_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft600_pkg.sv
// ft600_pkg
//   Definitions shared by the FT600 FIFO bus arbiter: the bus widths and the
//   arbiter state enumeration.
package ft600_pkg;

    localparam int FT_DATA_W = 16;
    localparam int FT_BE_W   = 2;

    // ST_RD_OE gives the FT600 one cycle with OE_N low before RD_N falls.
    // ST_GAP is the one-cycle bus turnaround after every burst.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_OE = 3'd1,
        ST_RD    = 3'd2,
        ST_WR    = 3'd3,
        ST_GAP   = 3'd4
    } ft_state_t;

endpackage

// File: rtl/ft600_fifo_arbiter.sv
// ft600_fifo_arbiter
//   Arbitrates the FT600 245-style synchronous FIFO bus between a read
//   stream (host -> FPGA) and a write stream (FPGA -> host). One FSM plus a
//   burst counter; bursts are capped at MAX_BURST words. When both
//   directions request at once, the direction opposite to the last grant wins.
//
// Parameters
//   MAX_BURST      maximum words per burst before arbitration is re-run
//
// Ports
//   i_ft_clk       FT600 bus clock; everything runs on its rising edge
//   i_rst          synchronous active-high reset
//   i_ft_data      sampled FT600 data bus
//   o_ft_data      data drive value, o_ft_data_oe enables the tristate
//   i_ft_be        sampled FT600 byte enables
//   o_ft_be        byte-enable drive value, o_ft_be_oe enables it
//   i_ft_txe_n     FT600 TX FIFO has space (active-low)
//   i_ft_rxf_n     FT600 RX FIFO has data (active-low)
//   o_ft_wr_n      write strobe (active-low)
//   o_ft_rd_n      read strobe (active-low)
//   o_ft_oe_n      FT600 output enable (active-low)
//   i_tx_data      TX stream word, i_tx_valid / o_tx_ready handshake
//   o_rx_data      RX stream word with o_rx_be, o_rx_valid one-cycle pulse
//   i_rx_ready     RX sink can take at least MAX_BURST words
//   o_busy         arbiter is not idle
//
// Build option
//   FT600_BE_EN    drive the byte enables during writes and capture i_ft_be
//                  on reads; when undefined, byte enables are never driven
//                  and every received word is reported as full (2'b11).
module ft600_fifo_arbiter
    import ft600_pkg::*;
#(
    parameter int MAX_BURST = 256
) (
    input  logic                 i_ft_clk,
    input  logic                 i_rst,
    input  logic [FT_DATA_W-1:0] i_ft_data,
    output logic [FT_DATA_W-1:0] o_ft_data,
    output logic                 o_ft_data_oe,
    input  logic [FT_BE_W-1:0]   i_ft_be,
    output logic [FT_BE_W-1:0]   o_ft_be,
    output logic                 o_ft_be_oe,
    input  logic                 i_ft_txe_n,
    input  logic                 i_ft_rxf_n,
    output logic                 o_ft_wr_n,
    output logic                 o_ft_rd_n,
    output logic                 o_ft_oe_n,
    input  logic [FT_DATA_W-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic [FT_DATA_W-1:0] o_rx_data,
    output logic [FT_BE_W-1:0]   o_rx_be,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_busy
);

    // Wide enough to hold MAX_BURST itself, so the count never wraps.
    localparam int              CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    ft_state_t          state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
    logic               last_wr, last_wr_nxt;
    logic               rd_req, wr_req;
    logic               rd_take, wr_take;
    logic               tx_ready;

    logic                 rx_vld_p1;
    logic [FT_DATA_W-1:0] rx_data_p1;

    assign rd_req  = !i_ft_rxf_n && i_rx_ready;
    assign wr_req  = !i_ft_txe_n && i_tx_valid;
    assign cnt_inc = cnt + 1'b1;

    assign tx_ready = (state == ST_WR) && !i_ft_txe_n && (cnt < BURST_MAX);
    assign rd_take  = (state == ST_RD) && !i_ft_rxf_n;
    assign wr_take  = i_tx_valid && tx_ready;

    // Strobes and enables decode straight from the state register, so an
    // exit edge into GAP releases them on the following cycle.
    assign o_busy       = (state != ST_IDLE);
    assign o_ft_oe_n    = !((state == ST_RD_OE) || (state == ST_RD));
    assign o_ft_rd_n    = (state != ST_RD);
    assign o_ft_data_oe = (state == ST_WR);
    assign o_ft_data    = o_ft_data_oe ? i_tx_data : '0;
    assign o_tx_ready   = tx_ready;
    assign o_ft_wr_n    = !wr_take;

    // Next-state, grant and burst counting
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        last_wr_nxt = last_wr;
        unique case (state)
            ST_IDLE: begin
                // On contention, grant read unless the last grant was read.
                if (rd_req && (!wr_req || last_wr)) begin
                    state_nxt   = ST_RD_OE;
                    last_wr_nxt = 1'b0;
                    cnt_nxt     = '0;
                end else if (wr_req) begin
                    state_nxt   = ST_WR;
                    last_wr_nxt = 1'b1;
                    cnt_nxt     = '0;
                end
            end
            ST_RD_OE: state_nxt = ST_RD;
            ST_RD: begin
                if (rd_take) begin
                    cnt_nxt = cnt_inc;
                end
                if (i_ft_rxf_n || (cnt_inc == BURST_MAX)) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_WR: begin
                if (wr_take) begin
                    cnt_nxt = cnt_inc;
                end
                if (i_ft_txe_n || !i_tx_valid || (wr_take && (cnt_inc == BURST_MAX))) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_ft_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            last_wr <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            last_wr <= last_wr_nxt;
        end
    end

    // Read capture: word sampled on the edge, presented for one cycle after
    always_ff @(posedge i_ft_clk) begin
        if (i_rst) begin
            rx_vld_p1  <= 1'b0;
            rx_data_p1 <= '0;
        end else begin
            rx_vld_p1 <= rd_take;
            if (rd_take) begin
                rx_data_p1 <= i_ft_data;
            end
        end
    end

    assign o_rx_valid = rx_vld_p1;
    assign o_rx_data  = rx_data_p1;

`ifdef FT600_BE_EN
    logic [FT_BE_W-1:0] rx_be_p1;

    always_ff @(posedge i_ft_clk) begin
        if (i_rst) begin
            rx_be_p1 <= '0;
        end else if (rd_take) begin
            rx_be_p1 <= i_ft_be;
        end
    end

    assign o_rx_be    = rx_be_p1;
    assign o_ft_be    = '1;
    assign o_ft_be_oe = o_ft_data_oe;
`else
    logic [FT_BE_W-1:0] unused_ft_be;

    assign unused_ft_be = i_ft_be;
    assign o_rx_be      = o_rx_valid ? '1 : '0;
    assign o_ft_be      = '0;
    assign o_ft_be_oe   = 1'b0;
`endif

endmodule

// File: tb/tb_ft600_fifo_arbiter.sv
// tb_ft600_fifo_arbiter
//   Two arbiters share one set of inputs: instance 0 with the default
//   MAX_BURST of 256 and instance 1 with MAX_BURST of 4. Each is compared
//   every cycle against a behavioural model of the bus protocol, and the
//   directed scenarios add scenario-level checks on top.
module tb_ft600_fifo_arbiter;

    localparam int P_IDLE = 0;
    localparam int P_OE   = 1;
    localparam int P_RD   = 2;
    localparam int P_WR   = 3;
    localparam int P_GAP  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ft_din;
    logic [1:0]  ft_bein;
    logic        txe_n, rxf_n;
    logic [15:0] tx_data;
    logic        tx_valid, rx_ready;

    logic [15:0] ft_dout [2];
    logic        ft_doe  [2];
    logic [1:0]  ft_beo  [2];
    logic        ft_beoe [2];
    logic        wr_n    [2];
    logic        rd_n    [2];
    logic        oe_n    [2];
    logic        tx_rdy  [2];
    logic [15:0] rxd_o   [2];
    logic [1:0]  rxbe_o  [2];
    logic        rxv_o   [2];
    logic        busy    [2];

    always #5 clk = ~clk;

    ft600_fifo_arbiter #(.MAX_BURST(256)) dut_a (
        .i_ft_clk(clk), .i_rst(rst), .i_ft_data(ft_din),
        .o_ft_data(ft_dout[0]), .o_ft_data_oe(ft_doe[0]),
        .i_ft_be(ft_bein), .o_ft_be(ft_beo[0]), .o_ft_be_oe(ft_beoe[0]),
        .i_ft_txe_n(txe_n), .i_ft_rxf_n(rxf_n),
        .o_ft_wr_n(wr_n[0]), .o_ft_rd_n(rd_n[0]), .o_ft_oe_n(oe_n[0]),
        .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_rdy[0]),
        .o_rx_data(rxd_o[0]), .o_rx_be(rxbe_o[0]), .o_rx_valid(rxv_o[0]),
        .i_rx_ready(rx_ready), .o_busy(busy[0])
    );

    ft600_fifo_arbiter #(.MAX_BURST(4)) dut_b (
        .i_ft_clk(clk), .i_rst(rst), .i_ft_data(ft_din),
        .o_ft_data(ft_dout[1]), .o_ft_data_oe(ft_doe[1]),
        .i_ft_be(ft_bein), .o_ft_be(ft_beo[1]), .o_ft_be_oe(ft_beoe[1]),
        .i_ft_txe_n(txe_n), .i_ft_rxf_n(rxf_n),
        .o_ft_wr_n(wr_n[1]), .o_ft_rd_n(rd_n[1]), .o_ft_oe_n(oe_n[1]),
        .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_rdy[1]),
        .o_rx_data(rxd_o[1]), .o_rx_be(rxbe_o[1]), .o_rx_valid(rxv_o[1]),
        .i_rx_ready(rx_ready), .o_busy(busy[1])
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model, one slot per instance
    int          mb   [2] = '{256, 4};
    int          ph   [2];
    int          cnt  [2];
    bit          lastw[2];
    logic        m_rxv[2];
    logic [15:0] m_rxd[2];
    logic [1:0]  m_rxbe[2];

    // Scenario observers
    int          cyc = 0;
    int          rxv_pulses0, wr_low0, first_oe0, first_rd0;
    logic [15:0] wr_words0[$];
    int          run1, max_run1;
    int          grants1[$];
    logic        prev_oe1, prev_doe1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int i);
        logic       e_rdy, e_wrn, e_doe;
        logic [1:0] e_rxbe, e_beo;
        logic       e_beoe;
        e_doe = (ph[i] == P_WR);
        e_rdy = e_doe && !txe_n && (cnt[i] < mb[i]);
        e_wrn = !(e_rdy && tx_valid);
`ifdef FT600_BE_EN
        e_rxbe = m_rxbe[i];
        e_beo  = 2'b11;
        e_beoe = e_doe;
`else
        e_rxbe = m_rxv[i] ? 2'b11 : 2'b00;
        e_beo  = 2'b00;
        e_beoe = 1'b0;
`endif
        chk($sformatf("busy%0d", i),     busy[i],    ph[i] != P_IDLE);
        chk($sformatf("oe_n%0d", i),     oe_n[i],    !(ph[i] == P_OE || ph[i] == P_RD));
        chk($sformatf("rd_n%0d", i),     rd_n[i],    ph[i] != P_RD);
        chk($sformatf("data_oe%0d", i),  ft_doe[i],  e_doe);
        chk($sformatf("ft_data%0d", i),  ft_dout[i], e_doe ? tx_data : 16'h0);
        chk($sformatf("tx_ready%0d", i), tx_rdy[i],  e_rdy);
        chk($sformatf("wr_n%0d", i),     wr_n[i],    e_wrn);
        chk($sformatf("rx_valid%0d", i), rxv_o[i],   m_rxv[i]);
        chk($sformatf("rx_data%0d", i),  rxd_o[i],   m_rxd[i]);
        chk($sformatf("rx_be%0d", i),    rxbe_o[i],  e_rxbe);
        chk($sformatf("ft_be%0d", i),    ft_beo[i],  e_beo);
        chk($sformatf("ft_be_oe%0d", i), ft_beoe[i], e_beoe);
    endtask

    task automatic model_step(input int i);
        bit rdq, wrq, xfer;
        if (rst) begin
            ph[i] = P_IDLE; cnt[i] = 0; lastw[i] = 1'b1;
            m_rxv[i] = 1'b0; m_rxd[i] = 16'h0; m_rxbe[i] = 2'b00;
            return;
        end
        m_rxv[i] = 1'b0;
        case (ph[i])
            P_IDLE: begin
                rdq = !rxf_n && rx_ready;
                wrq = !txe_n && tx_valid;
                if (rdq && wrq) begin
                    if (lastw[i]) begin ph[i] = P_OE; lastw[i] = 1'b0; end
                    else          begin ph[i] = P_WR; lastw[i] = 1'b1; end
                    cnt[i] = 0;
                end else if (rdq) begin
                    ph[i] = P_OE; lastw[i] = 1'b0; cnt[i] = 0;
                end else if (wrq) begin
                    ph[i] = P_WR; lastw[i] = 1'b1; cnt[i] = 0;
                end
            end
            P_OE: ph[i] = P_RD;
            P_RD: begin
                if (!rxf_n) begin
                    m_rxd[i] = ft_din; m_rxbe[i] = ft_bein; m_rxv[i] = 1'b1;
                    cnt[i]++;
                end
                if (rxf_n || cnt[i] >= mb[i]) ph[i] = P_GAP;
            end
            P_WR: begin
                xfer = tx_valid && !txe_n && (cnt[i] < mb[i]);
                if (xfer) cnt[i]++;
                if (txe_n || !tx_valid || cnt[i] == mb[i]) ph[i] = P_GAP;
            end
            default: ph[i] = P_IDLE;
        endcase
    endtask

    task automatic clear_obs();
        rxv_pulses0 = 0; wr_low0 = 0; first_oe0 = -1; first_rd0 = -1;
        wr_words0.delete();
        run1 = 0; max_run1 = 0;
        grants1.delete();
        prev_oe1 = 1'b1; prev_doe1 = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        if (rxv_o[0] === 1'b1) rxv_pulses0++;
        if (wr_n[0] === 1'b0) begin wr_low0++; wr_words0.push_back(ft_dout[0]); end
        if (oe_n[0] === 1'b0 && first_oe0 < 0) first_oe0 = cyc;
        if (rd_n[0] === 1'b0 && first_rd0 < 0) first_rd0 = cyc;
        if (wr_n[1] === 1'b0) begin
            run1++;
            if (run1 > max_run1) max_run1 = run1;
        end else begin
            run1 = 0;
        end
        if (oe_n[1] === 1'b0 && rd_n[1] === 1'b1 && prev_oe1 === 1'b1) grants1.push_back(0);
        if (ft_doe[1] === 1'b1 && prev_doe1 === 1'b0) grants1.push_back(1);
        prev_oe1  = oe_n[1];
        prev_doe1 = ft_doe[1];
        @(posedge clk);
        model_step(0);
        model_step(1);
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        txe_n = 1'b1; rxf_n = 1'b1; tx_valid = 1'b0; rx_ready = 1'b0;
        tx_data = 16'h0; ft_din = 16'h0; ft_bein = 2'b00;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int word;
        int guard;
        bit xfer_exp;

        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        clear_obs();
        tick();                      // reset state checked here
        rst = 1'b0;

        // Five-word read burst
        clear_obs();
        rx_ready = 1'b1;
        rxf_n    = 1'b0;
        for (int k = 0; k < 7; k++) begin
            ft_din  = 16'($urandom);
            ft_bein = 2'($urandom);
            tick();
        end
        rxf_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("rd_pulses", rxv_pulses0, 5);
        chk("oe_before_rd", first_rd0 - first_oe0, 1);
        chk("rd_back_idle", busy[0], 1'b0);

        // Four-word write stream, then source drops valid
        idle_inputs();
        clear_obs();
        txe_n    = 1'b0;
        tx_valid = 1'b1;
        word     = 1;
        tx_data  = 16'(word);
        guard    = 0;
        while (tx_valid && guard < 20) begin
            xfer_exp = (ph[0] == P_WR) && !txe_n && tx_valid && (cnt[0] < mb[0]);
            tick();
            guard++;
            if (xfer_exp) begin
                word++;
                if (word > 4) begin tx_valid = 1'b0; tx_data = 16'h0; end
                else          tx_data = 16'(word);
            end
        end
        chk("wr_stream_bound", guard < 20, 1'b1);
        for (int k = 0; k < 4; k++) tick();
        chk("wr_low_cycles", wr_low0, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < wr_words0.size()) chk($sformatf("wr_word%0d", k), wr_words0[k], 16'(k + 1));
            else                      chk($sformatf("wr_word%0d", k), 16'hxxxx, 16'(k + 1));
        end
        chk("tx_ready_after", tx_rdy[0], 1'b0);

        // Contention with continuous traffic on the 4-word instance
        idle_inputs();
        pulse_reset();
        clear_obs();
        txe_n = 1'b0; tx_valid = 1'b1; rxf_n = 1'b0; rx_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tx_data = 16'($urandom);
            ft_din  = 16'($urandom);
            ft_bein = 2'($urandom);
            tick();
        end
        chk("grant_count", grants1.size() >= 4, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k < grants1.size()) chk($sformatf("grant%0d", k), grants1[k], k % 2);
            else                    chk($sformatf("grant%0d", k), 32'hffff_ffff, k % 2);
        end
        chk("max_wr_run", max_run1, 4);

        // Reset in the middle of a read burst
        idle_inputs();
        pulse_reset();
        rxf_n = 1'b0; rx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ft_din = 16'($urandom);
            tick();
        end
        chk("mid_rd_before", rd_n[0], 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_rd_n", rd_n[0], 1'b1);
        chk("rst_oe_n", oe_n[0], 1'b1);
        chk("rst_wr_n", wr_n[0], 1'b1);
        chk("rst_rx_valid", rxv_o[0], 1'b0);
        chk("rst_busy", busy[0], 1'b0);
        clear_obs();
        for (int k = 0; k < 6; k++) begin
            ft_din = 16'($urandom);
            tick();
        end
        rxf_n = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("rd_after_rst", rxv_pulses0, 4);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            rst      = ($urandom_range(0, 60) == 0);
            rxf_n    = ($urandom_range(0, 3) == 0);
            txe_n    = ($urandom_range(0, 3) == 0);
            tx_valid = ($urandom_range(0, 3) != 0);
            rx_ready = ($urandom_range(0, 3) != 0);
            tx_data  = 16'($urandom);
            ft_din   = 16'($urandom);
            ft_bein  = 2'($urandom);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
